// File: rtl/genius_uc_pkg.sv
// Shared constants for the Genius (Simon) control unit: state codes and
// LED mux selector values.
package genius_pkg;

    // 4-bit state codes; db_estado reports these values directly.
    localparam logic [3:0] INICIAL       = 4'd0;
    localparam logic [3:0] PREPARA       = 4'd1;
    localparam logic [3:0] MOSTRA        = 4'd2;
    localparam logic [3:0] APAGA         = 4'd3;
    localparam logic [3:0] VERIFICA_EXIB = 4'd4;
    localparam logic [3:0] PROX_EXIB     = 4'd5;
    localparam logic [3:0] ZERA_END      = 4'd6;
    localparam logic [3:0] ESPERA        = 4'd7;
    localparam logic [3:0] REGISTRA      = 4'd8;
    localparam logic [3:0] COMPARA       = 4'd9;
    localparam logic [3:0] PROX_JOG      = 4'd10;
    localparam logic [3:0] PROX_RODADA   = 4'd11;
    localparam logic [3:0] FIM_ACERTO    = 4'd12;
    localparam logic [3:0] FIM_ERRO      = 4'd13;
    localparam logic [3:0] FIM_TIMEOUT   = 4'd14;

    // LED mux selector values.
    localparam logic [1:0] SEL_OFF = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_BOT = 2'd2;

endpackage

// File: rtl/genius_uc_if.sv
// Control/status bundle between the Genius control unit and its datapath.
// The master side (control unit) consumes status flags and drives controls;
// the slave side (datapath) does the opposite. There is no valid/ready
// handshake here: every control is a level or single-cycle pulse sampled by
// the datapath on each clock, and every status flag is sampled by the
// control unit on each clock.
interface genius_uc_if;
    // Status flags from the datapath plus the start request.
    logic       iniciar;
    logic       botoesIgualMemoria;
    logic       endecoIgualLimite;
    logic       fimL;
    logic       meioM;
    logic       fimM;
    logic       jogada_feita;
    logic       timeout;

    // Controls to the datapath.
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraM;
    logic       contaM;
    logic       zeraR;
    logic       registraR;
    logic       contaT;
    logic       selecionaMemoria;
    logic       reset_random;
    logic [1:0] seletor;

    // Game result and debug.
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout_out;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, botoesIgualMemoria, endecoIgualLimite, fimL,
               meioM, fimM, jogada_feita, timeout,
        output zeraE, contaE, zeraL, contaL, zeraM, contaM, zeraR,
               registraR, contaT, selecionaMemoria, reset_random, seletor,
               pronto, ganhou, perdeu, timeout_out, db_estado
    );

    modport slave (
        output iniciar, botoesIgualMemoria, endecoIgualLimite, fimL,
               meioM, fimM, jogada_feita, timeout,
        input  zeraE, contaE, zeraL, contaL, zeraM, contaM, zeraR,
               registraR, contaT, selecionaMemoria, reset_random, seletor,
               pronto, ganhou, perdeu, timeout_out, db_estado
    );
endinterface

// File: rtl/genius_uc.sv
// Genius (Simon) control unit: Moore FSM that shows the sequence up to the
// current limit, then collects and compares the player's moves, growing the
// limit each round until win, loss or timeout.
module genius_uc
    import genius_pkg::*;
#(
    parameter int TIMEOUT_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    genius_uc_if.master bus
);

    localparam logic w_timeout_en = (TIMEOUT_EN != 0);

    logic [3:0] r_estado;
    logic [3:0] w_proximo;

    // State register; reset may strike at any time, including mid-display.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_proximo;
    end

    // Next-state logic; each transition takes exactly one clock.
    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:       w_proximo = bus.iniciar ? PREPARA : INICIAL;
            PREPARA:       w_proximo = MOSTRA;
            MOSTRA:        w_proximo = bus.meioM ? APAGA : MOSTRA;
            APAGA:         w_proximo = bus.fimM ? VERIFICA_EXIB : APAGA;
            VERIFICA_EXIB: w_proximo = bus.endecoIgualLimite ? ZERA_END : PROX_EXIB;
            PROX_EXIB:     w_proximo = MOSTRA;
            ZERA_END:      w_proximo = ESPERA;
            ESPERA: begin
                // A press wins over a timeout arriving in the same cycle.
                if (bus.jogada_feita)                      w_proximo = REGISTRA;
                else if (bus.timeout && w_timeout_en)      w_proximo = FIM_TIMEOUT;
                else                                       w_proximo = ESPERA;
            end
            REGISTRA:      w_proximo = COMPARA;
            COMPARA: begin
                if (!bus.botoesIgualMemoria)     w_proximo = FIM_ERRO;
                else if (!bus.endecoIgualLimite) w_proximo = PROX_JOG;
                else if (bus.fimL)               w_proximo = FIM_ACERTO;
                else                             w_proximo = PROX_RODADA;
            end
            PROX_JOG:      w_proximo = ESPERA;
            PROX_RODADA:   w_proximo = MOSTRA;
            // Restart from an end state keeps the current limit.
            FIM_ACERTO:    w_proximo = bus.iniciar ? PREPARA : FIM_ACERTO;
            FIM_ERRO:      w_proximo = bus.iniciar ? PREPARA : FIM_ERRO;
            FIM_TIMEOUT:   w_proximo = bus.iniciar ? PREPARA : FIM_TIMEOUT;
            default:       w_proximo = INICIAL;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        bus.zeraE            = 1'b0;
        bus.contaE           = 1'b0;
        bus.zeraL            = 1'b0;
        bus.contaL           = 1'b0;
        bus.zeraM            = 1'b0;
        bus.contaM           = 1'b0;
        bus.zeraR            = 1'b0;
        bus.registraR        = 1'b0;
        bus.contaT           = 1'b0;
        bus.selecionaMemoria = 1'b0;
        bus.reset_random     = 1'b0;
        bus.seletor          = SEL_OFF;
        bus.pronto           = 1'b0;
        bus.ganhou           = 1'b0;
        bus.perdeu           = 1'b0;
        bus.timeout_out      = 1'b0;
        case (r_estado)
            PREPARA: begin
                bus.zeraE            = 1'b1;
                bus.zeraM            = 1'b1;
                bus.zeraR            = 1'b1;
                bus.selecionaMemoria = 1'b1;
            end
            MOSTRA: begin
                bus.seletor = SEL_MEM;
                bus.contaM  = 1'b1;
            end
            APAGA:         bus.contaM = 1'b1;
            VERIFICA_EXIB: bus.zeraM  = 1'b1;
            PROX_EXIB:     bus.contaE = 1'b1;
            ZERA_END: begin
                bus.zeraE = 1'b1;
                bus.zeraR = 1'b1;
            end
            ESPERA: begin
                bus.seletor = SEL_BOT;
                bus.contaT  = w_timeout_en;
            end
            REGISTRA: begin
                bus.registraR = 1'b1;
                bus.seletor   = SEL_BOT;
            end
            COMPARA:       bus.seletor = SEL_BOT;
            // contaT low here restarts the move-wait timer.
            PROX_JOG:      bus.contaE = 1'b1;
            PROX_RODADA: begin
                bus.contaL = 1'b1;
                bus.zeraE  = 1'b1;
                bus.zeraM  = 1'b1;
            end
            FIM_ACERTO: begin
                bus.pronto  = 1'b1;
                bus.ganhou  = 1'b1;
                bus.seletor = SEL_MEM;
            end
            FIM_ERRO: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                bus.pronto      = 1'b1;
                bus.perdeu      = 1'b1;
                bus.timeout_out = 1'b1;
            end
            default: begin
                // INICIAL and the unused code 15 share the idle outputs.
                bus.reset_random = 1'b1;
                bus.zeraE        = 1'b1;
                bus.zeraL        = 1'b1;
                bus.zeraM        = 1'b1;
                bus.zeraR        = 1'b1;
            end
        endcase
    end

    assign bus.db_estado = r_estado;

endmodule
